id_stage_pipelined: RTL and testbench

//  Parametrised decode stage for the 5-stage RISC-V core: opcode field split, control decode,

---
 rtl/id_stage_pipelined_if.sv | 58 +++++
 rtl/id_stage_pipelined.sv | 179 +++++++++++++++++
 tb/tb_id_stage_pipelined.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipelined_if.sv
// Decode-stage bus: IF/ID + WB inputs in, ID/EX register contents out.
// slave = decode stage side, master = the pipeline around it.
interface id_stage_pipelined_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int RA = $clog2(NREGS);

  logic            valid_id;
  logic [XLEN-1:0] pc_id;
  logic [31:0]     instruction_id;
  logic            flush;
  logic            regwrite_wb;
  logic [RA-1:0]   rd_wb;
  logic [XLEN-1:0] data_wb;

  logic            stall_id;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [RA-1:0]   ex_rs1;
  logic [RA-1:0]   ex_rs2;
  logic [RA-1:0]   ex_rd;
  logic [2:0]      ex_funct3;
  logic [6:0]      ex_funct7;
  logic [6:0]      ex_opcode;
  logic            ex_regwrite;
  logic            ex_memtoreg;
  logic            ex_memread;
  logic            ex_memwrite;
  logic            ex_alusrc;
  logic            ex_branch;
  logic [1:0]      ex_aluop;

  modport slave (
    input  valid_id, pc_id, instruction_id, flush,
    input  regwrite_wb, rd_wb, data_wb,
    output stall_id, ex_valid, ex_pc, ex_imm,
    output ex_rs1_data, ex_rs2_data,
    output ex_rs1, ex_rs2, ex_rd,
    output ex_funct3, ex_funct7, ex_opcode,
    output ex_regwrite, ex_memtoreg, ex_memread,
    output ex_memwrite, ex_alusrc, ex_branch, ex_aluop
  );

  modport master (
    output valid_id, pc_id, instruction_id, flush,
    output regwrite_wb, rd_wb, data_wb,
    input  stall_id, ex_valid, ex_pc, ex_imm,
    input  ex_rs1_data, ex_rs2_data,
    input  ex_rs1, ex_rs2, ex_rd,
    input  ex_funct3, ex_funct7, ex_opcode,
    input  ex_regwrite, ex_memtoreg, ex_memread,
    input  ex_memwrite, ex_alusrc, ex_branch, ex_aluop
  );
endinterface

// File: rtl/id_stage_pipelined.sv
// Decode stage: control decode, immediates, register file with WB bypass,
// load-use stall, flush bubbles, and the ID/EX register (ports: clk, reset, bus).
module id_stage_pipelined #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit BYPASS_EN = 1'b1,
  parameter bit HAZARD_EN = 1'b1
) (
  input logic clk,
  input logic reset,
  id_stage_pipelined_if.slave bus
);
  localparam int RA = $clog2(NREGS);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [RA-1:0]   rs1;
    logic [RA-1:0]   rs2;
    logic [RA-1:0]   rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [6:0]      opcode;
    logic            regwrite;
    logic            memtoreg;
    logic            memread;
    logic            memwrite;
    logic            alusrc;
    logic            branch;
    logic [1:0]      aluop;
  } id_ex_t;

  id_ex_t ex_d, ex_q;

  logic [XLEN-1:0] rf_d [NREGS];
  logic [XLEN-1:0] rf_q [NREGS];

  logic [31:0]     ins;
  logic [6:0]      opcode;
  logic [RA-1:0]   rs1, rs2, rd;
  logic            is_r, is_i, is_ld, is_st, is_br;
  logic [7:0]      ctrl;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            wb_act;
  logic            use1, use2;
  logic            haz;

  assign ins    = bus.instruction_id;
  assign opcode = ins[6:0];
  assign rd     = RA'(ins[11:7]);
  assign rs1    = RA'(ins[19:15]);
  assign rs2    = RA'(ins[24:20]);

  assign is_r  = (opcode == OP_R);
  assign is_i  = (opcode == OP_I);
  assign is_ld = (opcode == OP_LD);
  assign is_st = (opcode == OP_ST);
  assign is_br = (opcode == OP_BR);

  // ctrl = {regwrite, memtoreg, memread, memwrite, alusrc, branch, aluop}
  always_comb begin
    ctrl = '0;
    imm  = '0;
    unique case (1'b1)
      is_r: ctrl = 8'b1000_0010;
      is_i: begin
        ctrl = 8'b1000_1010;
        imm  = {{(XLEN-12){ins[31]}}, ins[31:20]};
      end
      is_ld: begin
        ctrl = 8'b1110_1000;
        imm  = {{(XLEN-12){ins[31]}}, ins[31:20]};
      end
      is_st: begin
        ctrl = 8'b0001_1000;
        imm  = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
      end
      is_br: begin
        ctrl = 8'b0000_0101;
        imm  = {{(XLEN-13){ins[31]}}, ins[31], ins[7],
                ins[30:25], ins[11:8], 1'b0};
      end
      default: begin
        ctrl = '0;
        imm  = '0;
      end
    endcase
  end

  assign wb_act = bus.regwrite_wb && (bus.rd_wb != '0);

  always_comb begin
    rf_d = rf_q;
    if (wb_act) rf_d[bus.rd_wb] = bus.data_wb;
  end

  // Same-cycle WB write is forwarded straight onto the read port.
  always_comb begin
    rs1_val = rf_q[rs1];
    rs2_val = rf_q[rs2];
    if (BYPASS_EN && wb_act && bus.rd_wb == rs1) rs1_val = bus.data_wb;
    if (BYPASS_EN && wb_act && bus.rd_wb == rs2) rs2_val = bus.data_wb;
    if (rs1 == '0) rs1_val = '0;
    if (rs2 == '0) rs2_val = '0;
  end

  assign use1 = is_r | is_i | is_ld | is_st | is_br;
  assign use2 = is_r | is_st | is_br;

  assign haz = HAZARD_EN && bus.valid_id && ex_q.valid
            && ex_q.memread && (ex_q.rd != '0)
            && ((use1 && ex_q.rd == rs1) || (use2 && ex_q.rd == rs2));

  assign bus.stall_id = haz && !bus.flush && !reset;

  // Flush and load-use both insert an all-zero bubble.
  always_comb begin
    ex_d = '0;
    if (!(bus.flush || haz)) begin
      ex_d.valid    = bus.valid_id;
      ex_d.pc       = bus.pc_id;
      ex_d.imm      = imm;
      ex_d.rs1_data = rs1_val;
      ex_d.rs2_data = rs2_val;
      ex_d.rs1      = rs1;
      ex_d.rs2      = rs2;
      ex_d.rd       = rd;
      ex_d.funct3   = ins[14:12];
      ex_d.funct7   = ins[31:25];
      ex_d.opcode   = opcode;
      ex_d.regwrite = ctrl[7];
      ex_d.memtoreg = ctrl[6];
      ex_d.memread  = ctrl[5];
      ex_d.memwrite = ctrl[4];
      ex_d.alusrc   = ctrl[3];
      ex_d.branch   = ctrl[2];
      ex_d.aluop    = ctrl[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
      rf_q <= '{default: '0};
    end else begin
      ex_q <= ex_d;
      rf_q <= rf_d;
    end
  end

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_pc       = ex_q.pc;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_rs1_data = ex_q.rs1_data;
  assign bus.ex_rs2_data = ex_q.rs2_data;
  assign bus.ex_rs1      = ex_q.rs1;
  assign bus.ex_rs2      = ex_q.rs2;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_funct3   = ex_q.funct3;
  assign bus.ex_funct7   = ex_q.funct7;
  assign bus.ex_opcode   = ex_q.opcode;
  assign bus.ex_regwrite = ex_q.regwrite;
  assign bus.ex_memtoreg = ex_q.memtoreg;
  assign bus.ex_memread  = ex_q.memread;
  assign bus.ex_memwrite = ex_q.memwrite;
  assign bus.ex_alusrc   = ex_q.alusrc;
  assign bus.ex_branch   = ex_q.branch;
  assign bus.ex_aluop    = ex_q.aluop;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: decode, bypass (on/off),
// load-use stall, flush, x0 handling and reset during a stall.
module tb_id_stage_pipelined;
  logic clk;
  logic reset;
  int   tests;
  int   failed;

  id_stage_pipelined_if #(.XLEN(32), .NREGS(32)) bus ();
  id_stage_pipelined_if #(.XLEN(32), .NREGS(32)) bus0 ();

  id_stage_pipelined #(.BYPASS_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  id_stage_pipelined #(.BYPASS_EN(1'b0)) u_nbp (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  assign bus0.valid_id       = bus.valid_id;
  assign bus0.pc_id          = bus.pc_id;
  assign bus0.instruction_id = bus.instruction_id;
  assign bus0.flush          = bus.flush;
  assign bus0.regwrite_wb    = bus.regwrite_wb;
  assign bus0.rd_wb          = bus.rd_wb;
  assign bus0.data_wb        = bus.data_wb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [4:0] rd, logic [4:0] rs1,
                                        logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] rd,
                                        logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, 3'd0, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [4:0] rs1, logic [4:0] rs2,
                                        logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(logic [4:0] rs1, logic [4:0] rs2,
                                        logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11],
            7'b1100011};
  endfunction

  task automatic drive(logic [31:0] pc, logic [31:0] ins);
    bus.valid_id       = 1'b1;
    bus.pc_id          = pc;
    bus.instruction_id = ins;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    bus.valid_id       = 1'b0;
    bus.pc_id          = '0;
    bus.instruction_id = '0;
    bus.flush          = 1'b0;
    bus.regwrite_wb    = 1'b0;
    bus.rd_wb          = '0;
    bus.data_wb        = '0;
    tick();
    tick();
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_regwrite", bus.ex_regwrite, 0);
    chk("rst_imm", bus.ex_imm, 0);
    chk("rst_stall", bus.stall_id, 0);

    // T1: addi x1,x0,5
    reset = 1'b0;
    drive(32'h100, enc_i(7'b0010011, 5'd1, 5'd0, 12'd5));
    tick();
    chk("t1_valid", bus.ex_valid, 1);
    chk("t1_imm", bus.ex_imm, 5);
    chk("t1_regwrite", bus.ex_regwrite, 1);
    chk("t1_alusrc", bus.ex_alusrc, 1);
    chk("t1_aluop", bus.ex_aluop, 2);
    chk("t1_rd", bus.ex_rd, 1);
    chk("t1_pc", bus.ex_pc, 32'h100);
    chk("t1_memread", bus.ex_memread, 0);

    // T2: WB x3=DEAD while add x4,x3,x0 reads it
    drive(32'h104, enc_r(5'd4, 5'd3, 5'd0));
    bus.regwrite_wb = 1'b1;
    bus.rd_wb       = 5'd3;
    bus.data_wb     = 32'hDEAD;
    tick();
    bus.regwrite_wb = 1'b0;
    chk("t2_bypass", bus.ex_rs1_data, 32'hDEAD);
    chk("t2_nobypass", bus0.ex_rs1_data, 0);
    chk("t2_alusrc", bus.ex_alusrc, 0);
    chk("t2_opcode", bus.ex_opcode, 7'b0110011);
    tick();
    chk("t2_nbp_later", bus0.ex_rs1_data, 32'hDEAD);

    // T3: lw x5,0(x1) ; add x6,x5,x2 with x2 written to 0x22
    bus.regwrite_wb = 1'b1;
    bus.rd_wb       = 5'd2;
    bus.data_wb     = 32'h22;
    drive(32'h108, enc_i(7'b0000011, 5'd5, 5'd1, 12'd0));
    tick();
    bus.regwrite_wb = 1'b0;
    chk("t3_ld_memread", bus.ex_memread, 1);
    chk("t3_ld_memtoreg", bus.ex_memtoreg, 1);
    chk("t3_ld_aluop", bus.ex_aluop, 0);
    drive(32'h10C, enc_r(5'd6, 5'd5, 5'd2));
    #1;
    chk("t3_stall", bus.stall_id, 1);
    tick();
    chk("t3_bubble_valid", bus.ex_valid, 0);
    chk("t3_bubble_regwr", bus.ex_regwrite, 0);
    chk("t3_stall_clear", bus.stall_id, 0);
    tick();
    chk("t3_add_valid", bus.ex_valid, 1);
    chk("t3_add_rd", bus.ex_rd, 6);
    chk("t3_add_rs1", bus.ex_rs1, 5);
    chk("t3_add_rs2data", bus.ex_rs2_data, 32'h22);
    chk("t3_add_pc", bus.ex_pc, 32'h10C);

    // T4: flush during a would-be stall
    drive(32'h110, enc_i(7'b0000011, 5'd5, 5'd1, 12'd0));
    tick();
    drive(32'h114, enc_r(5'd6, 5'd5, 5'd2));
    bus.flush = 1'b1;
    #1;
    chk("t4_flush_nostall", bus.stall_id, 0);
    tick();
    bus.flush = 1'b0;
    chk("t4_flush_bubble", bus.ex_valid, 0);
    drive(32'h118, enc_i(7'b0000011, 5'd5, 5'd1, 12'd0));
    tick();
    drive(32'h11C, enc_s(5'd0, 5'd5, 12'd4));
    #1;
    chk("t4_sw_stall", bus.stall_id, 1);
    tick();
    chk("t4_sw_bubble", bus.ex_valid, 0);
    tick();
    chk("t4_sw_memwrite", bus.ex_memwrite, 1);
    chk("t4_sw_imm", bus.ex_imm, 4);
    chk("t4_sw_rs2", bus.ex_rs2, 5);
    chk("t4_sw_regwrite", bus.ex_regwrite, 0);
    drive(32'h120, enc_b(5'd0, 5'd0, 13'h1FF8));
    tick();
    chk("t4_br_imm", bus.ex_imm, 32'hFFFF_FFF8);
    chk("t4_br_branch", bus.ex_branch, 1);
    chk("t4_br_aluop", bus.ex_aluop, 1);

    // T5: writes to x0 are dropped; rd=0 load never stalls
    bus.regwrite_wb = 1'b1;
    bus.rd_wb       = 5'd0;
    bus.data_wb     = 32'hFFFF;
    drive(32'h124, enc_r(5'd7, 5'd0, 5'd0));
    tick();
    bus.regwrite_wb = 1'b0;
    chk("t5_x0_bypass", bus.ex_rs1_data, 0);
    drive(32'h128, enc_i(7'b0000011, 5'd0, 5'd1, 12'd0));
    tick();
    drive(32'h12C, enc_r(5'd8, 5'd0, 5'd0));
    #1;
    chk("t5_x0_nostall", bus.stall_id, 0);
    tick();
    chk("t5_x0_valid", bus.ex_valid, 1);
    chk("t5_x0_read", bus.ex_rs2_data, 0);
    drive(32'h130, 32'h0000_12B7);
    tick();
    chk("t5_lui_regwr", bus.ex_regwrite, 0);
    chk("t5_lui_imm", bus.ex_imm, 0);

    // T6: reset during a stall cycle
    drive(32'h134, enc_i(7'b0000011, 5'd5, 5'd1, 12'd0));
    tick();
    drive(32'h138, enc_r(5'd6, 5'd5, 5'd2));
    #1;
    chk("t6_stall", bus.stall_id, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_valid", bus.ex_valid, 0);
    chk("t6_memread", bus.ex_memread, 0);
    chk("t6_rd", bus.ex_rd, 0);
    chk("t6_pc", bus.ex_pc, 0);
    chk("t6_stall_clear", bus.stall_id, 0);
    drive(32'h13C, enc_r(5'd4, 5'd3, 5'd0));
    tick();
    chk("t6_rf_cleared", bus.ex_rs1_data, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
